// File: rtl/ram_upload.sv
// Host upload port for the CPU dpram: halts the CPU, then serves ioctl byte reads
// from port a, with out-of-range offsets returning 8'hFF.
module ram_upload #(
    parameter logic [11:0] BASE    = 12'h800,
    parameter int          SIZE    = 512,
    parameter int          MEM_LAT = 1
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_upload,
    input  logic        ioctl_rd,
    input  logic [24:0] ioctl_addr,
    output logic [7:0]  ioctl_din,
    output logic        ioctl_wait,
    output logic        cpu_hold,
    input  logic        hold_ack,
    output logic        mem_sel,
    output logic [11:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_q,
    output logic [7:0]  checksum,
    output logic        overrun
);

    typedef enum logic [2:0] {
        IDLE, HOLD, READY, FETCH, WAIT, LATCH
    } state_t;

    state_t     state;
    logic       hit;
    logic [1:0] cnt;
    logic       in_range;
    logic       busy;
    logic [7:0] data;

    assign in_range = ioctl_addr < 25'(SIZE);
    assign busy     = state inside {FETCH, WAIT, LATCH};
    assign data     = hit ? mem_q : 8'hFF;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= IDLE;
            hit        <= 1'b0;
            cnt        <= 2'd0;
            ioctl_din  <= 8'h00;
            ioctl_wait <= 1'b0;
            cpu_hold   <= 1'b0;
            mem_sel    <= 1'b0;
            mem_addr   <= 12'h000;
            mem_rd     <= 1'b0;
            checksum   <= 8'h00;
            overrun    <= 1'b0;
        end else begin
            mem_rd <= 1'b0;
            // Requests the FSM cannot take are dropped, but remembered.
            if (ioctl_upload && ioctl_rd && (state == HOLD || busy))
                overrun <= 1'b1;

            if (!ioctl_upload) begin
                state      <= IDLE;
                cpu_hold   <= 1'b0;
                mem_sel    <= 1'b0;
                ioctl_wait <= 1'b0;
            end else if (state != IDLE && state != HOLD && !hold_ack) begin
                state      <= HOLD;
                mem_sel    <= 1'b0;
                ioctl_wait <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        state      <= HOLD;
                        cpu_hold   <= 1'b1;
                        ioctl_wait <= 1'b1;
                        checksum   <= 8'h00;
                        overrun    <= 1'b0;
                    end
                    HOLD: begin
                        if (hold_ack) begin
                            state      <= READY;
                            mem_sel    <= 1'b1;
                            ioctl_wait <= 1'b0;
                        end
                    end
                    READY: begin
                        if (ioctl_rd) begin
                            state      <= FETCH;
                            hit        <= in_range;
                            mem_rd     <= in_range;
                            ioctl_wait <= 1'b1;
                            if (in_range)
                                mem_addr <= BASE + ioctl_addr[11:0];
                        end
                    end
                    FETCH: begin
                        if (!hit || MEM_LAT == 1) begin
                            state <= LATCH;
                        end else begin
                            state <= WAIT;
                            cnt   <= 2'(MEM_LAT - 2);
                        end
                    end
                    WAIT: begin
                        if (cnt == 2'd0)
                            state <= LATCH;
                        else
                            cnt <= cnt - 2'd1;
                    end
                    LATCH: begin
                        state      <= READY;
                        ioctl_din  <= data;
                        checksum   <= checksum + data;
                        ioctl_wait <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ram_upload.sv
// Bench for ram_upload: dpram and CPU hold models, scoreboard of returned bytes
// and checksums, plus directed session, range, overrun and abort scenarios.
module tb_ram_upload;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_upload;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        cpu_hold;
    logic        hold_ack;
    logic        mem_sel;
    logic [11:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_q = 8'h00;
    logic [7:0]  checksum;
    logic        overrun;

    ram_upload dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .ioctl_upload (ioctl_upload),
        .ioctl_rd     (ioctl_rd),
        .ioctl_addr   (ioctl_addr),
        .ioctl_din    (ioctl_din),
        .ioctl_wait   (ioctl_wait),
        .cpu_hold     (cpu_hold),
        .hold_ack     (hold_ack),
        .mem_sel      (mem_sel),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_q        (mem_q),
        .checksum     (checksum),
        .overrun      (overrun)
    );

    always #5 clk_sys = ~clk_sys;

    logic [7:0] mem [4096];
    logic [1:0] hsr = 2'b00;
    logic       ack_en;
    int         rd_cnt = 0;
    int         sel_viol = 0;

    always @(posedge clk_sys) begin
        if (mem_rd) mem_q <= mem[mem_addr];
        hsr <= {hsr[0], cpu_hold};
        if (mem_rd) rd_cnt <= rd_cnt + 1;
        if (mem_rd && !mem_sel) sel_viol <= sel_viol + 1;
    end
    assign hold_ack = hsr[1] & ack_en;

    typedef struct {
        logic [7:0] din;
        logic [7:0] sum;
    } exp_t;

    exp_t       sbq[$];
    bit         pending = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_sum = 8'h00;
    int         rd_base;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk_sys);
            #2;
            if (pending && !ioctl_wait) begin
                if (sbq.size() == 0) begin
                    chk("sb_underflow", 32'd0, 32'd1);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_din", ioctl_din, e.din);
                    chk("sb_sum", checksum, e.sum);
                end
                pending = 1'b0;
            end
        end
    end

    task automatic do_rd(input logic [24:0] a, input logic [7:0] e,
                         input bit push);
        ioctl_addr = a;
        ioctl_rd   = 1'b1;
        if (push) begin
            exp_sum = exp_sum + e;
            sbq.push_back('{din: e, sum: exp_sum});
            pending = 1'b1;
        end
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 20 && pending; k++) @(negedge clk_sys);
        if (pending) begin
            chk("byte_timeout", 32'd1, 32'd0);
            pending = 1'b0;
            sbq.delete();
        end
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 20 && !mem_sel; k++) @(negedge clk_sys);
        chk("ready_sel", mem_sel, 1);
        chk("ready_wait", ioctl_wait, 0);
    endtask

    task automatic start_session();
        ioctl_upload = 1'b1;
        @(negedge clk_sys);
        chk("hold_on", cpu_hold, 1);
        chk("hold_wait", ioctl_wait, 1);
        chk("hold_sel", mem_sel, 0);
        chk("sess_sum", checksum, 0);
        chk("sess_ovr", overrun, 0);
        exp_sum = 8'h00;
        wait_ready();
    endtask

    task automatic end_session();
        ioctl_upload = 1'b0;
        repeat (5) @(negedge clk_sys);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_din"}, ioctl_din, 0);
        chk({tag, "_wait"}, ioctl_wait, 0);
        chk({tag, "_hold"}, cpu_hold, 0);
        chk({tag, "_sel"}, mem_sel, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_rd"}, mem_rd, 0);
        chk({tag, "_sum"}, checksum, 0);
        chk({tag, "_ovr"}, overrun, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, required test end");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        ioctl_upload = 1'b0;
        ioctl_rd     = 1'b0;
        ioctl_addr   = '0;
        ack_en       = 1'b1;
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i);
        mem[12'h800] = 8'h5A;
        repeat (3) @(negedge clk_sys);
        chk_reset("rst");
        reset = 1'b0;
        @(negedge clk_sys);
        chk("idle_hold", cpu_hold, 0);

        // First byte with exact latency
        start_session();
        do_rd(25'h0, 8'h5A, 1'b1);
        chk("lat_rd", mem_rd, 1);
        chk("lat_addr", mem_addr, 12'h800);
        chk("lat_wait1", ioctl_wait, 1);
        @(negedge clk_sys);
        chk("lat_wait2", ioctl_wait, 1);
        @(negedge clk_sys);
        chk("lat_wait3", ioctl_wait, 0);
        chk("lat_din", ioctl_din, 8'h5A);
        chk("lat_sum", checksum, 8'h5A);
        wait_done();
        end_session();

        // Full in-range sweep
        mem[12'h800] = 8'h00;
        start_session();
        for (int a = 0; a < 512; a++) begin
            do_rd(25'(a), 8'(a), 1'b1);
            wait_done();
        end
        chk("sweep_sum", checksum, 8'h00);
        chk("sweep_ovr", overrun, 0);

        // Out-of-range offsets
        rd_base = rd_cnt;
        do_rd(25'h200, 8'hFF, 1'b1);
        wait_done();
        chk("oor1_sum", checksum, 8'hFF);
        do_rd(25'h1FFFFFF, 8'hFF, 1'b1);
        wait_done();
        chk("oor2_sum", checksum, 8'hFE);
        chk("oor_din", ioctl_din, 8'hFF);
        chk("oor_no_rd", rd_cnt - rd_base, 0);

        // Back-to-back request overruns
        do_rd(25'h5, 8'h05, 1'b1);
        ioctl_addr = 25'h6;
        ioctl_rd   = 1'b1;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        wait_done();
        repeat (4) @(negedge clk_sys);
        chk("ovr_set", overrun, 1);
        chk("ovr_din", ioctl_din, 8'h05);
        chk("ovr_sum", checksum, 8'h03);
        chk("ovr_wait", ioctl_wait, 0);
        do_rd(25'h7, 8'h07, 1'b1);
        wait_done();
        chk("ovr_sticky", overrun, 1);
        end_session();
        chk("ovr_held", overrun, 1);
        chk("sum_held", checksum, 8'h0A);

        // Upload dropped mid-fetch
        start_session();
        do_rd(25'h3, 8'h03, 1'b1);
        wait_done();
        do_rd(25'h9, 8'h00, 1'b0);
        ioctl_upload = 1'b0;
        @(negedge clk_sys);
        chk("drop_hold", cpu_hold, 0);
        chk("drop_sel", mem_sel, 0);
        chk("drop_wait", ioctl_wait, 0);
        chk("drop_din", ioctl_din, 8'h03);
        repeat (3) @(negedge clk_sys);
        chk("drop_din2", ioctl_din, 8'h03);
        chk("drop_sum", checksum, 8'h03);
        repeat (2) @(negedge clk_sys);

        // hold_ack lost mid-fetch
        start_session();
        do_rd(25'h4, 8'h00, 1'b0);
        ack_en = 1'b0;
        @(negedge clk_sys);
        chk("ack_wait", ioctl_wait, 1);
        chk("ack_sel", mem_sel, 0);
        chk("ack_hold", cpu_hold, 1);
        ack_en = 1'b1;
        wait_ready();
        chk("ack_din", ioctl_din, 8'h03);
        chk("ack_sum", checksum, 8'h00);
        do_rd(25'h10, 8'h10, 1'b1);
        wait_done();
        end_session();

        // Reset during HOLD
        ack_en       = 1'b0;
        ioctl_upload = 1'b1;
        @(negedge clk_sys);
        chk("hrst_hold", cpu_hold, 1);
        @(negedge clk_sys);
        reset = 1'b1;
        @(negedge clk_sys);
        chk_reset("hrst");
        reset = 1'b0;
        @(negedge clk_sys);
        chk("hrst_rehold", cpu_hold, 1);
        ioctl_upload = 1'b0;
        ack_en       = 1'b1;
        repeat (3) @(negedge clk_sys);

        chk("sel_viol", sel_viol, 0);
        chk("sb_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_upload.md
RAM_UPLOAD -- requirements
Module: ram_upload

Interface
REQ-001 Parameter BASE, default 12'h800, SHALL be the first memory address mapped to upload offset 0.
REQ-002 Parameter SIZE, default 512, SHALL be the number of bytes served from memory; offsets at or above SIZE are out of range.
REQ-003 Parameter MEM_LAT, default 1, SHALL be the number of cycles from mem_rd to valid mem_q, range 1-3.
REQ-004 Port clk_sys, input, 1: the single clock, the same clock as the dpram and CPU.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port ioctl_upload, input, 1: level; high for the whole upload session.
REQ-007 Port ioctl_rd, input, 1: one-cycle byte request strobe.
REQ-008 Port ioctl_addr, input, 25: byte offset of the requested byte.
REQ-009 Port ioctl_din, output, 8: upload byte returned to the host.
REQ-010 Port ioctl_wait, output, 1: host stall; high while a request is pending.
REQ-011 Port cpu_hold, output, 1: CPU stall request, drives WAIT_N inverted at the top level.
REQ-012 Port hold_ack, input, 1: CPU is halted and the dpram port a is free.
REQ-013 Port mem_sel, output, 1: this block owns dpram port a address mux.
REQ-014 Port mem_addr, output, 12: dpram port a address.
REQ-015 Port mem_rd, output, 1: one-cycle memory read strobe.
REQ-016 Port mem_q, input, 8: dpram port a read data.
REQ-017 Port checksum, output, 8: running sum of bytes returned this session.
REQ-018 Port overrun, output, 1: sticky flag; set when ioctl_rd is ignored.

Function
REQ-019 The FSM SHALL have the states IDLE, HOLD, READY, FETCH, WAIT, LATCH.
REQ-020 IDLE: on ioctl_upload=1 go to HOLD, assert cpu_hold and clear checksum and overrun.
REQ-021 HOLD: cpu_hold=1; go to READY when hold_ack=1; wait indefinitely otherwise; ioctl_wait=1 while in HOLD.
REQ-022 READY: mem_sel=1; on ioctl_rd, capture ioctl_addr, set ioctl_wait=1 next cycle, and go to FETCH.
REQ-023 In-range request (ioctl_addr < SIZE), FETCH: mem_addr=BASE+ioctl_addr[11:0] (12-bit wrap) and mem_rd=1 for exactly 1 cycle.
REQ-024 In-range request, WAIT: hold for MEM_LAT-1 cycles, then go to LATCH.
REQ-025 Out-of-range request: skip the memory access (no mem_rd) and LATCH the value 8'hFF.
REQ-026 LATCH: ioctl_din<=data, checksum<=checksum+data mod 256, ioctl_wait<=0, return to READY.
REQ-027 Latency for in-range MEM_LAT=1: ioctl_rd at cycle t -> mem_rd at t+1 -> ioctl_din valid and ioctl_wait low at t+3.
REQ-028 An ioctl_rd arriving outside READY (HOLD, FETCH, WAIT, LATCH) SHALL be ignored and SHALL set overrun; ioctl_din is unchanged.
REQ-029 ioctl_rd in the same cycle as LATCH SHALL be ignored and SHALL set overrun.
REQ-030 ioctl_upload falling in any state SHALL deassert cpu_hold, mem_sel and ioctl_wait the next cycle and return the FSM to IDLE.
REQ-031 When ioctl_upload falls, an in-flight byte SHALL be discarded and checksum and overrun SHALL be held.
REQ-032 hold_ack falling while in READY/FETCH/WAIT/LATCH SHALL return the FSM to HOLD, abort any in-flight byte and keep ioctl_wait=1; checksum is unaffected.
REQ-033 mem_sel SHALL be 0 in IDLE and HOLD.
REQ-034 mem_rd SHALL never assert unless mem_sel=1 in the same cycle.
REQ-035 The block SHALL never write memory.

Reset
REQ-036 Reset SHALL force state=IDLE, ioctl_din=8'h00, ioctl_wait=0, cpu_hold=0, mem_sel=0, mem_addr=12'h000, mem_rd=0, checksum=8'h00, overrun=0.
REQ-037 Reset SHALL take priority over all inputs, including mid-FETCH or mid-HOLD, and takes effect on the next clock edge.
REQ-038 After reset, a still-high ioctl_upload SHALL restart the session via HOLD on the next cycle.

Verification
REQ-039 Upload session; hold_ack 2 cycles after cpu_hold; mem[0x800]=0x5A; ioctl_rd, addr 0 -> mem_addr=0x800 and mem_rd at t+1; ioctl_din=0x5A and ioctl_wait low at t+3; checksum=0x5A.
REQ-040 Read offsets 0x000-0x1FF sequentially, memory filled with addr[7:0] -> every byte matches; checksum=0x00; overrun=0.
REQ-041 ioctl_rd with addr 0x200, then with addr 0x1FFFFFF -> ioctl_din=0xFF each time; mem_rd is never asserted; checksum increases by 0xFF per byte.
REQ-042 Second ioctl_rd 1 cycle after the first -> overrun=1; only the first byte is returned; overrun stays set until the next session or reset.
REQ-043 Drop ioctl_upload during WAIT -> cpu_hold, mem_sel and ioctl_wait are low the next cycle; state=IDLE; ioctl_din is unchanged.
REQ-044 Assert reset during HOLD with hold_ack=0 -> all outputs are at reset values next cycle; with ioctl_upload still high, cpu_hold re-asserts one cycle after reset is released.
